// File: rtl/seg7_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Package  : seg7_pkg                                                        |
// | Brief    : Active-low 7-segment patterns shared by encoder and decoder.    |
// | Revision : 1.0  initial release                                            |
// +----------------------------------------------------------------------------+
package seg7_pkg;

    localparam int SEG_A = 6;
    localparam int SEG_B = 5;
    localparam int SEG_C = 4;
    localparam int SEG_D = 3;
    localparam int SEG_E = 2;
    localparam int SEG_F = 1;
    localparam int SEG_G = 0;

    localparam logic [6:0] SEG_N_BLANK = 7'b1111111;

    localparam logic [6:0] SEG_N_DIGIT [0:9] = '{
        7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110, 7'b1001100,
        7'b0100100, 7'b0100000, 7'b0001101, 7'b0000000, 7'b0000100
    };

    typedef struct packed {
        logic       legal;
        logic       blank;
        logic [3:0] bcd;
    } seg7_dec_t;

endpackage
`default_nettype wire

// File: rtl/seg7_pattern_decode.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : seg7_pattern_decode                                             |
// | Brief    : Combinational active-low segment pattern to BCD/blank decode.   |
// | Revision : 1.0  initial release                                            |
// +----------------------------------------------------------------------------+
module seg7_pattern_decode
    import seg7_pkg::*;
(
    input  logic [6:0] i_seg_n,
    output seg7_dec_t  o_dec
);

    always_comb begin
        o_dec = '0;
        if (i_seg_n == SEG_N_BLANK) begin
            o_dec.legal = 1'b1;
            o_dec.blank = 1'b1;
            o_dec.bcd   = 4'hF;
        end else begin
            for (int i = 0; i < 10; i++) begin
                if (i_seg_n == SEG_N_DIGIT[i]) begin
                    o_dec.legal = 1'b1;
                    o_dec.bcd   = 4'(i);
                end
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/seg7_scan_decoder.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : seg7_scan_decoder                                               |
// | Brief    : Recovers BCD digits from a multiplexed active-low display bus.  |
// | Revision : 1.0  initial release                                            |
// +----------------------------------------------------------------------------+
module seg7_scan_decoder
    import seg7_pkg::*;
#(
    parameter int NUM_DIGITS     = 4,
    parameter int STABLE_CYCLES  = 4,
    parameter int TIMEOUT_CYCLES = 1048576
)(
    input  logic                          clk,
    input  logic                          rst,
    input  logic [6:0]                    seg_n,
    input  logic [NUM_DIGITS-1:0]         an_n,
    output logic [4*NUM_DIGITS-1:0]       digits_o,
    output logic [NUM_DIGITS-1:0]         blank_o,
    output logic                          frame_vld,
    output logic                          pat_err,
    output logic [$clog2(NUM_DIGITS)-1:0] err_idx,
    output logic                          stale
);

    localparam int IDX_W   = $clog2(NUM_DIGITS);
    localparam int DWELL_W = $clog2(STABLE_CYCLES + 1);
    localparam int STALE_W = $clog2(TIMEOUT_CYCLES + 1);

    localparam logic [DWELL_W-1:0]    c_dwell_one = DWELL_W'(1);
    localparam logic [DWELL_W-1:0]    c_dwell_max = DWELL_W'(STABLE_CYCLES);
    localparam logic [DWELL_W-1:0]    c_dwell_pre = DWELL_W'(STABLE_CYCLES - 1);
    localparam logic [STALE_W-1:0]    c_stale_one = STALE_W'(1);
    localparam logic [STALE_W-1:0]    c_stale_max = STALE_W'(TIMEOUT_CYCLES);
    localparam logic [NUM_DIGITS-1:0] c_sel_one   = NUM_DIGITS'(1);

    logic [6:0]              r_smp_seg, r_prev_seg;
    logic [NUM_DIGITS-1:0]   r_smp_an, r_prev_an;
    logic [DWELL_W-1:0]      r_dwell;
    logic [4*NUM_DIGITS-1:0] r_shadow;
    logic [NUM_DIGITS-1:0]   r_shadow_blank;
    logic [NUM_DIGITS-1:0]   r_mask;
    logic [STALE_W-1:0]      r_stale_cnt;

    logic                    w_same;
    logic [NUM_DIGITS-1:0]   w_sel;
    logic                    w_onehot;
    logic [IDX_W-1:0]        w_idx;
    logic                    w_cap;
    logic                    w_frame;
    seg7_dec_t               w_dec;
    logic [4*NUM_DIGITS-1:0] w_shadow_next;
    logic [NUM_DIGITS-1:0]   w_blank_next;
    logic [NUM_DIGITS-1:0]   w_mask_next;

    seg7_pattern_decode u_decode (
        .i_seg_n (r_smp_seg),
        .o_dec   (w_dec)
    );

    // Capture only on the single edge where the dwell crosses into STABLE_CYCLES.
    assign w_same   = (r_smp_seg == r_prev_seg) && (r_smp_an == r_prev_an);
    assign w_sel    = ~r_smp_an;
    assign w_onehot = (w_sel != '0) && ((w_sel & (w_sel - c_sel_one)) == '0);
    assign w_cap    = w_same && (r_dwell == c_dwell_pre) && w_onehot;
    assign w_frame  = w_cap && w_dec.legal && (&w_mask_next);
    assign stale    = (r_stale_cnt >= c_stale_max);

    always_comb begin
        w_idx = '0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (w_sel[i]) begin
                w_idx = IDX_W'(i);
            end
        end
    end

    always_comb begin
        w_shadow_next = r_shadow;
        w_blank_next  = r_shadow_blank;
        w_mask_next   = r_mask;
        if (w_cap && w_dec.legal) begin
            w_shadow_next[int'(w_idx)*4 +: 4] = w_dec.bcd;
            w_blank_next[w_idx]               = w_dec.blank;
            w_mask_next[w_idx]                = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_smp_seg      <= '0;
            r_smp_an       <= '0;
            r_prev_seg     <= '0;
            r_prev_an      <= '0;
            r_dwell        <= '0;
            r_shadow       <= '0;
            r_shadow_blank <= '0;
            r_mask         <= '0;
            r_stale_cnt    <= '0;
            digits_o       <= '0;
            blank_o        <= '0;
            frame_vld      <= 1'b0;
            pat_err        <= 1'b0;
            err_idx        <= '0;
        end else begin
            r_smp_seg  <= seg_n;
            r_smp_an   <= an_n;
            r_prev_seg <= r_smp_seg;
            r_prev_an  <= r_smp_an;

            if (!w_same) begin
                r_dwell <= c_dwell_one;
            end else if (r_dwell != c_dwell_max) begin
                r_dwell <= r_dwell + c_dwell_one;
            end

            r_shadow       <= w_shadow_next;
            r_shadow_blank <= w_blank_next;
            r_mask         <= w_frame ? '0 : w_mask_next;
            frame_vld      <= w_frame;
            pat_err        <= w_cap && !w_dec.legal;

            if (w_cap && !w_dec.legal) begin
                err_idx <= w_idx;
            end

            // The completing digit is taken from the next-state shadow, not the register.
            if (w_frame) begin
                digits_o <= w_shadow_next;
                blank_o  <= w_blank_next;
            end

            if (w_frame) begin
                r_stale_cnt <= '0;
            end else if (r_stale_cnt != c_stale_max) begin
                r_stale_cnt <= r_stale_cnt + c_stale_one;
            end
        end
    end

endmodule
`default_nettype wire
